seg14_scan_decoder: RTL and testbench

- Receive side of the 12-digit multiplexed 14-segment display bus (one-hot `sel[11:0]` plus glyph `segm[13:0]`, one digit per clk).
- Samples the bus, decodes each glyph back to a 6-bit character code and assembles a 12-character frame.
- Reports frame-complete and sequencing/glyph errors.
- Used as a loopback checker and readback path behind the display drivers, in the same clock domain.

---
 rtl/seg14_pkg.sv | 66 ++++++
 rtl/seg14_glyph_decode.sv | 23 ++
 rtl/seg14_scan_decoder.sv | 124 ++++++++++++
 tb/tb_seg14_scan_decoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg14_pkg.sv
// Shared font, character codes and FSM state type for the 14-segment bus readback path.
// Glyph bits, MSB first: a b c d e f g1 g2 h i j k l m.
package seg14_pkg;

  localparam int SEG_W  = 14;
  localparam int CODE_W = 6;

  typedef enum logic {HUNT, CAPTURE} state_t;

  localparam logic [CODE_W-1:0] CODE_SPACE = 6'h00;
  localparam logic [CODE_W-1:0] CODE_A     = 6'h01;
  localparam logic [CODE_W-1:0] CODE_DIG0  = 6'h20;
  localparam logic [CODE_W-1:0] CODE_UNK   = 6'h3F;

  localparam logic [SEG_W-1:0] GLYPH_SPACE = 14'b00000000000000;
  localparam logic [SEG_W-1:0] GLYPH_A = 14'b11101111000000;
  localparam logic [SEG_W-1:0] GLYPH_B = 14'b11110001010010;
  localparam logic [SEG_W-1:0] GLYPH_C = 14'b10011100000000;
  localparam logic [SEG_W-1:0] GLYPH_D = 14'b11110000010010;
  localparam logic [SEG_W-1:0] GLYPH_E = 14'b10011110000000;
  localparam logic [SEG_W-1:0] GLYPH_F = 14'b10001110000000;
  localparam logic [SEG_W-1:0] GLYPH_G = 14'b10111101000000;
  localparam logic [SEG_W-1:0] GLYPH_H = 14'b01101111000000;
  localparam logic [SEG_W-1:0] GLYPH_I = 14'b10010000010010;
  localparam logic [SEG_W-1:0] GLYPH_J = 14'b01111000000000;
  localparam logic [SEG_W-1:0] GLYPH_K = 14'b00001110001100;
  localparam logic [SEG_W-1:0] GLYPH_L = 14'b00011100000000;
  localparam logic [SEG_W-1:0] GLYPH_M = 14'b01101100101000;
  localparam logic [SEG_W-1:0] GLYPH_N = 14'b01101100100100;
  localparam logic [SEG_W-1:0] GLYPH_O = 14'b11111100000000;
  localparam logic [SEG_W-1:0] GLYPH_P = 14'b11001111000000;
  localparam logic [SEG_W-1:0] GLYPH_Q = 14'b11111100000100;
  localparam logic [SEG_W-1:0] GLYPH_R = 14'b11001111000100;
  localparam logic [SEG_W-1:0] GLYPH_S = 14'b10110111000000;
  localparam logic [SEG_W-1:0] GLYPH_T = 14'b10000000010010;
  localparam logic [SEG_W-1:0] GLYPH_U = 14'b01111100000000;
  localparam logic [SEG_W-1:0] GLYPH_V = 14'b00001100001001;
  localparam logic [SEG_W-1:0] GLYPH_W = 14'b01101100000101;
  localparam logic [SEG_W-1:0] GLYPH_X = 14'b00000000101101;
  localparam logic [SEG_W-1:0] GLYPH_Y = 14'b00000000101010;
  localparam logic [SEG_W-1:0] GLYPH_Z = 14'b10010000001001;

  localparam logic [SEG_W-1:0] GLYPH_0 = 14'b11111100001001;
  localparam logic [SEG_W-1:0] GLYPH_1 = 14'b01100000001000;
  localparam logic [SEG_W-1:0] GLYPH_2 = 14'b11011011000000;
  localparam logic [SEG_W-1:0] GLYPH_3 = 14'b11110001000000;
  localparam logic [SEG_W-1:0] GLYPH_4 = 14'b01100111000000;
  localparam logic [SEG_W-1:0] GLYPH_5 = 14'b10110111000000;
  localparam logic [SEG_W-1:0] GLYPH_6 = 14'b10111111000000;
  localparam logic [SEG_W-1:0] GLYPH_7 = 14'b11100000000000;
  localparam logic [SEG_W-1:0] GLYPH_8 = 14'b11111111000000;
  localparam logic [SEG_W-1:0] GLYPH_9 = 14'b11110111000000;

  // Index i holds the glyph for code CODE_A+i (letters) or CODE_DIG0+i (digits).
  localparam logic [SEG_W-1:0] FONT_ALPHA [26] = '{
    GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F, GLYPH_G, GLYPH_H, GLYPH_I,
    GLYPH_J, GLYPH_K, GLYPH_L, GLYPH_M, GLYPH_N, GLYPH_O, GLYPH_P, GLYPH_Q, GLYPH_R,
    GLYPH_S, GLYPH_T, GLYPH_U, GLYPH_V, GLYPH_W, GLYPH_X, GLYPH_Y, GLYPH_Z
  };

  localparam logic [SEG_W-1:0] FONT_DIGIT [10] = '{
    GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4,
    GLYPH_5, GLYPH_6, GLYPH_7, GLYPH_8, GLYPH_9
  };

endpackage

// File: rtl/seg14_glyph_decode.sv
// Combinational reverse font lookup: 14-segment pattern to 6-bit character code.
module seg14_glyph_decode
  import seg14_pkg::*;
(
  input  logic [SEG_W-1:0]  segm,
  output logic [CODE_W-1:0] code,
  output logic              unknown
);

  // Letters are scanned after digits so a shared pattern (S/5) resolves to the letter.
  always_comb begin
    code = CODE_UNK;
    for (int i = 0; i < 10; i++) begin
      if (segm == FONT_DIGIT[i]) code = CODE_DIG0 + CODE_W'(i);
    end
    for (int i = 0; i < 26; i++) begin
      if (segm == FONT_ALPHA[i]) code = CODE_A + CODE_W'(i);
    end
    if (segm == GLYPH_SPACE) code = CODE_SPACE;
    unknown = (code == CODE_UNK);
  end

endmodule

// File: rtl/seg14_scan_decoder.sv
// Receive side of the multiplexed 14-segment display bus: samples sel/segm, decodes glyphs
// and assembles complete frames, flagging sequencing errors and unknown glyphs.
module seg14_scan_decoder
  import seg14_pkg::*;
#(
  parameter int NDIG = 12,
  parameter int CW   = 6,
  parameter int CNTW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NDIG-1:0]      sel,
  input  logic [SEG_W-1:0]     segm,
  output logic [NDIG*CW-1:0]   frame,
  output logic                 frame_valid,
  output logic                 frame_bad,
  output logic                 seq_err,
  output logic [CNTW-1:0]      frame_cnt
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t               state;
  logic [NDIG-1:0]      in_sel;
  logic [SEG_W-1:0]     in_segm;
  logic [NDIG*CW-1:0]   buffer;
  logic [NDIG*CW-1:0]   next_buf;
  logic [IW-1:0]        exp_idx;
  logic [IW-1:0]        idx;
  logic                 unk;
  logic                 sel_onehot;
  logic                 last_digit;
  logic [CODE_W-1:0]    dec_code;
  logic                 dec_unk;

  seg14_glyph_decode u_decode (
    .segm    (in_segm),
    .code    (dec_code),
    .unknown (dec_unk)
  );

  assign sel_onehot = (in_sel != '0) && ((in_sel & (in_sel - NDIG'(1))) == '0);
  assign last_digit = (idx == IW'(NDIG - 1));

  always_comb begin
    idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (in_sel[i]) idx = IW'(i);
    end
  end

  // Buffer as it would look with the current digit written; frame loads this at completion.
  always_comb begin
    next_buf = buffer;
    next_buf[idx*CW +: CW] = dec_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_sel      <= '0;
      in_segm     <= '0;
      buffer      <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      frame_bad   <= 1'b0;
      seq_err     <= 1'b0;
      frame_cnt   <= '0;
      state       <= HUNT;
      exp_idx     <= '0;
      unk         <= 1'b0;
    end else begin
      in_sel      <= sel;
      in_segm     <= segm;
      frame_valid <= 1'b0;
      seq_err     <= 1'b0;
      case (state)
        HUNT: begin
          if (in_sel == NDIG'(1)) begin
            buffer  <= next_buf;
            exp_idx <= IW'(1);
            unk     <= dec_unk;
            state   <= CAPTURE;
          end else if ((in_sel != '0) && !sel_onehot) begin
            seq_err <= 1'b1;
          end
        end
        CAPTURE: begin
          if (in_sel != '0) begin
            if (!sel_onehot) begin
              seq_err <= 1'b1;
              state   <= HUNT;
            end else if (idx == exp_idx) begin
              buffer <= next_buf;
              unk    <= unk | dec_unk;
              if (last_digit) begin
                frame       <= next_buf;
                frame_valid <= 1'b1;
                frame_bad   <= unk | dec_unk;
                frame_cnt   <= frame_cnt + CNTW'(1);
                state       <= HUNT;
              end else begin
                exp_idx <= exp_idx + IW'(1);
              end
            end else if (idx == exp_idx - IW'(1)) begin
              // Same digit still on the bus for another scan cycle.
              buffer <= next_buf;
              unk    <= unk | dec_unk;
            end else if (idx == '0) begin
              seq_err <= 1'b1;
              buffer  <= next_buf;
              exp_idx <= IW'(1);
              unk     <= dec_unk;
            end else begin
              seq_err <= 1'b1;
              state   <= HUNT;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_seg14_scan_decoder.sv
// Self-checking bench for seg14_scan_decoder: directed scenarios plus random bus traffic,
// compared cycle by cycle against a character-level reference model.
module tb_seg14_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] sel = '0;
  logic [13:0] segm = '0;
  logic [71:0] frame;
  logic        frame_valid;
  logic        frame_bad;
  logic        seq_err;
  logic [7:0]  frame_cnt;

  int vectorCount = 0;
  int missCount = 0;
  int pulseCount = 0;
  int errCount = 0;

  string       tbChars = " ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
  logic [13:0] tbFont [37] = '{
    14'b00000000000000,
    14'b11101111000000, 14'b11110001010010, 14'b10011100000000, 14'b11110000010010,
    14'b10011110000000, 14'b10001110000000, 14'b10111101000000, 14'b01101111000000,
    14'b10010000010010, 14'b01111000000000, 14'b00001110001100, 14'b00011100000000,
    14'b01101100101000, 14'b01101100100100, 14'b11111100000000, 14'b11001111000000,
    14'b11111100000100, 14'b11001111000100, 14'b10110111000000, 14'b10000000010010,
    14'b01111100000000, 14'b00001100001001, 14'b01101100000101, 14'b00000000101101,
    14'b00000000101010, 14'b10010000001001,
    14'b11111100001001, 14'b01100000001000, 14'b11011011000000, 14'b11110001000000,
    14'b01100111000000, 14'b10110111000000, 14'b10111111000000, 14'b11100000000000,
    14'b11111111000000, 14'b11110111000000
  };

  // Reference model state, kept at the level of characters and digit positions.
  bit          capturing;
  int          nextDigit;
  bit          anyUnk;
  int          modelBuf [12];
  bit          expValid, expErr, expBad;
  int          expCnt;
  logic [71:0] expFrame;

  seg14_scan_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel         (sel),
    .segm        (segm),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_bad   (frame_bad),
    .seq_err     (seq_err),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [71:0] actual, input logic [71:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int charCode(input byte c);
    if (c == " ") return 0;
    if (c >= "A" && c <= "Z") return int'(c) - int'("A") + 1;
    return 32 + int'(c) - int'("0");
  endfunction

  // First match in table order; letters precede digits so S/5 reads back as S.
  function automatic int modelDecode(input logic [13:0] g);
    for (int i = 0; i < 37; i++) begin
      if (tbFont[i] == g) return charCode(tbChars[i]);
    end
    return 63;
  endfunction

  function automatic logic [13:0] glyphOf(input byte c);
    for (int i = 0; i < 37; i++) begin
      if (tbChars[i] == c) return tbFont[i];
    end
    return 14'h3FFF;
  endfunction

  task automatic modelReset();
    capturing = 0; nextDigit = 0; anyUnk = 0;
    expValid = 0; expErr = 0; expBad = 0; expCnt = 0; expFrame = '0;
    for (int i = 0; i < 12; i++) modelBuf[i] = 0;
  endtask

  task automatic startFrame(input int code, input bit unk);
    modelBuf[0] = code; nextDigit = 1; anyUnk = unk; capturing = 1;
  endtask

  task automatic modelStep(input logic [11:0] s, input logic [13:0] g);
    int code, ones, k;
    bit unk;
    expValid = 0;
    expErr = 0;
    code = modelDecode(g);
    unk = (code == 63);
    ones = $countones(s);
    k = 0;
    for (int i = 0; i < 12; i++) if (s[i]) k = i;
    if (ones == 0) return;
    if (ones > 1) begin
      expErr = 1; capturing = 0;
    end else if (!capturing) begin
      if (k == 0) startFrame(code, unk);
    end else if (k == nextDigit) begin
      modelBuf[k] = code;
      anyUnk = anyUnk | unk;
      if (k == 11) begin
        for (int i = 0; i < 12; i++) expFrame[i*6 +: 6] = 6'(modelBuf[i]);
        expValid = 1; expBad = anyUnk; expCnt = (expCnt + 1) % 256; capturing = 0;
      end else begin
        nextDigit++;
      end
    end else if (k == nextDigit - 1) begin
      modelBuf[k] = code;
      anyUnk = anyUnk | unk;
    end else if (k == 0) begin
      expErr = 1; startFrame(code, unk);
    end else begin
      expErr = 1; capturing = 0;
    end
  endtask

  // Outputs seen after this edge belong to the sample driven on the previous call.
  task automatic applyStimulus(input logic [11:0] s, input logic [13:0] g);
    sel = s;
    segm = g;
    @(posedge clk);
    #1;
    checkOutput("frame_valid", 72'(frame_valid), 72'(expValid));
    checkOutput("seq_err", 72'(seq_err), 72'(expErr));
    checkOutput("frame_cnt", 72'(frame_cnt), 72'(expCnt));
    checkOutput("frame_bad", 72'(frame_bad), 72'(expBad));
    checkOutput("frame", frame, expFrame);
    if (frame_valid) pulseCount++;
    if (seq_err) errCount++;
    modelStep(s, g);
  endtask

  task automatic sendDigit(input int k, input logic [13:0] g);
    applyStimulus(12'(1 << k), g);
  endtask

  task automatic sendFrame(input string txt);
    for (int k = 0; k < 12; k++) sendDigit(k, glyphOf(txt[k]));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", 72'(frame_valid), 72'(0));
    checkOutput("rst_err", 72'(seq_err), 72'(0));
    checkOutput("rst_cnt", 72'(frame_cnt), 72'(0));
    checkOutput("rst_bad", 72'(frame_bad), 72'(0));
    checkOutput("rst_frame", frame, 72'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    int luisCodes [12] = '{12, 21, 9, 19, 0, 1, 12, 2, 5, 18, 20, 15};
    logic [71:0] luisFrame;
    int p0, e0, pos, r;
    logic [13:0] g;

    modelReset();
    #3;
    doReset();

    $display("[TB] normal frame");
    sendFrame("LUIS ALBERTO");
    applyStimulus('0, '0);
    for (int i = 0; i < 12; i++) luisFrame[i*6 +: 6] = 6'(luisCodes[i]);
    checkOutput("luis_frame", frame, luisFrame);
    checkOutput("luis_cnt", 72'(frame_cnt), 72'(1));
    checkOutput("luis_bad", 72'(frame_bad), 72'(0));

    $display("[TB] continuous frames with counter wrap");
    doReset();
    pulseCount = 0;
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < 12; k++) sendDigit(k, tbFont[$urandom_range(0, 36)]);
    end
    applyStimulus('0, '0);
    checkOutput("wrap_pulses", 72'(pulseCount), 72'(256));
    checkOutput("wrap_cnt", 72'(frame_cnt), 72'(0));

    $display("[TB] unknown glyph");
    for (int k = 0; k < 12; k++) sendDigit(k, (k == 4) ? 14'h3FFF : glyphOf(byte'("LUIS ALBERTO" >> (8 * (11 - k)))));
    applyStimulus('0, '0);
    checkOutput("unk_bad", 72'(frame_bad), 72'(1));
    checkOutput("unk_digit4", 72'(frame[4*6 +: 6]), 72'(6'h3F));
    sendFrame("CLEAN 0S5789");
    applyStimulus('0, '0);
    checkOutput("clean_bad", 72'(frame_bad), 72'(0));

    $display("[TB] skipped digit and illegal select");
    p0 = pulseCount;
    e0 = errCount;
    sendDigit(0, glyphOf("A"));
    sendDigit(1, glyphOf("B"));
    sendDigit(2, glyphOf("C"));
    sendDigit(5, glyphOf("D"));
    applyStimulus(12'b000000000011, glyphOf("E"));
    applyStimulus('0, '0);
    sendFrame("RECOVERED 42");
    applyStimulus('0, '0);
    checkOutput("skip_errs", 72'(errCount - e0), 72'(2));
    checkOutput("skip_pulses", 72'(pulseCount - p0), 72'(1));

    $display("[TB] idle and hold");
    p0 = pulseCount;
    e0 = errCount;
    for (int k = 0; k < 6; k++) sendDigit(k, tbFont[k + 8]);
    repeat (3) applyStimulus('0, '0);
    sendDigit(6, glyphOf("X"));
    sendDigit(6, glyphOf("Y"));
    for (int k = 7; k < 12; k++) sendDigit(k, tbFont[k + 20]);
    applyStimulus('0, '0);
    checkOutput("hold_errs", 72'(errCount - e0), 72'(0));
    checkOutput("hold_pulses", 72'(pulseCount - p0), 72'(1));

    $display("[TB] async reset mid-frame");
    for (int k = 0; k < 8; k++) sendDigit(k, tbFont[k + 1]);
    doReset();
    p0 = pulseCount;
    for (int k = 8; k < 12; k++) sendDigit(k, tbFont[k]);
    applyStimulus('0, '0);
    checkOutput("rst_partial", 72'(pulseCount - p0), 72'(0));
    sendFrame("AFTER RESET1");
    applyStimulus('0, '0);
    checkOutput("rst_full", 72'(pulseCount - p0), 72'(1));

    $display("[TB] random traffic");
    pos = 0;
    for (int n = 0; n < 3000; n++) begin
      g = ($urandom_range(0, 9) == 0) ? 14'($urandom_range(0, 16383)) : tbFont[$urandom_range(0, 36)];
      r = int'($urandom_range(0, 99));
      if (r < 80) begin
        sendDigit(pos, g);
        pos = (pos + 1) % 12;
      end else if (r < 88) begin
        sendDigit((pos + 11) % 12, g);
      end else if (r < 93) begin
        applyStimulus('0, g);
      end else if (r < 96) begin
        sendDigit(int'($urandom_range(0, 11)), g);
      end else begin
        applyStimulus(12'($urandom_range(1, 4095)), g);
      end
    end
    applyStimulus('0, '0);
    applyStimulus('0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
